seq_divider: RTL and testbench

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/seq_divider_if.sv | 24 ++
 rtl/seq_divider.sv | 140 ++++++++++++++
 tb/tb_seq_divider.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/seq_divider_if.sv
// Handshake and result bundle for seq_divider.
// master drives the request; slave (the divider) returns status and results.
interface seq_divider_if #(
   parameter int unsigned WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_by_zero;

   modport master (
      output start, dividend, divisor,
      input  busy, done, quotient, remainder, div_by_zero
   );

   modport slave (
      input  start, dividend, divisor,
      output busy, done, quotient, remainder, div_by_zero
   );
endinterface

// File: rtl/seq_divider.sv
// Sequential restoring divider, one quotient bit per cycle, MSB first.
// Define DIV_SIGNED_EN for two's-complement operands (truncating toward zero).
module seq_divider #(
   parameter int unsigned WIDTH = 8
) (
   input logic         clk,
   input logic         rst_n,
   seq_divider_if.slave bus
);
   localparam int unsigned CntW = $clog2(WIDTH + 1);
   localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

   typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

   state_e           state_q, state_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic [WIDTH:0]   prem_q, prem_d;
   logic [WIDTH-1:0] shq_q, shq_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic             dbz_q, dbz_d;

   logic [WIDTH:0]   shifted, trial;
   logic [WIDTH-1:0] quo_next, rem_next;
   logic [WIDTH-1:0] a_mag, b_mag, q_fin, r_fin;

`ifdef DIV_SIGNED_EN
   logic qneg_q, qneg_d, rneg_q, rneg_d;

   always_comb begin
      a_mag = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
      b_mag = bus.divisor[WIDTH-1]  ? -bus.divisor  : bus.divisor;
      q_fin = qneg_q ? -quo_next : quo_next;
      r_fin = rneg_q ? -rem_next : rem_next;
   end
`else
   always_comb begin
      a_mag = bus.dividend;
      b_mag = bus.divisor;
      q_fin = quo_next;
      r_fin = rem_next;
   end
`endif

   // Trial subtraction; the MSB of trial is the borrow (shifted < divisor).
   always_comb begin
      shifted  = {prem_q[WIDTH-1:0], shq_q[WIDTH-1]};
      trial    = shifted - {1'b0, dvs_q};
      quo_next = {shq_q[WIDTH-2:0], ~trial[WIDTH]};
      rem_next = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      prem_d  = prem_q;
      shq_d   = shq_q;
      dvs_d   = dvs_q;
      quo_d   = quo_q;
      rem_d   = rem_q;
      dbz_d   = dbz_q;
`ifdef DIV_SIGNED_EN
      qneg_d  = qneg_q;
      rneg_d  = rneg_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (bus.start) begin
               cnt_d   = '0;
               prem_d  = '0;
               dvs_d   = b_mag;
               // Zero divisor keeps the raw dividend so it can be returned as remainder.
               shq_d   = (bus.divisor == '0) ? bus.dividend : a_mag;
`ifdef DIV_SIGNED_EN
               qneg_d  = bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
               rneg_d  = bus.dividend[WIDTH-1];
`endif
               state_d = StCalc;
            end
         end
         StCalc: begin
            if (dvs_q == '0) begin
               quo_d   = '1;
               rem_d   = shq_q;
               dbz_d   = 1'b1;
               state_d = StDone;
            end else begin
               prem_d = trial[WIDTH] ? shifted : trial;
               shq_d  = quo_next;
               cnt_d  = cnt_q + CntW'(1);
               if (cnt_q == LastCnt) begin
                  quo_d   = q_fin;
                  rem_d   = r_fin;
                  dbz_d   = 1'b0;
                  state_d = StDone;
               end
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         prem_q  <= '0;
         shq_q   <= '0;
         dvs_q   <= '0;
         quo_q   <= '0;
         rem_q   <= '0;
         dbz_q   <= 1'b0;
`ifdef DIV_SIGNED_EN
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         prem_q  <= prem_d;
         shq_q   <= shq_d;
         dvs_q   <= dvs_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
         dbz_q   <= dbz_d;
`ifdef DIV_SIGNED_EN
         qneg_q  <= qneg_d;
         rneg_q  <= rneg_d;
`endif
      end
   end

   assign bus.busy        = (state_q == StCalc);
   assign bus.done        = (state_q == StDone);
   assign bus.quotient    = quo_q;
   assign bus.remainder   = rem_q;
   assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_divider.sv
// Directed-vector bench for seq_divider at WIDTH=8.
// Signed vectors are used when DIV_SIGNED_EN is defined.
module tb_seq_divider;
   localparam int unsigned WIDTH = 8;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_total = 0;
   int   n_bad   = 0;
   int   lat;

   seq_divider_if #(.WIDTH(WIDTH)) bus ();

   seq_divider #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Pulse start for one edge, then count edges until done (bounded).
   task automatic do_div(input logic [7:0] a, input logic [7:0] b, output int cycles);
      bus.start    = 1'b1;
      bus.dividend = a;
      bus.divisor  = b;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      cycles    = 0;
      while (!bus.done && cycles < 40) begin
         @(posedge clk);
         #1;
         cycles++;
      end
   endtask

   task automatic div_check(input string tag, input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] eq, input logic [7:0] er, input logic edbz,
                            input int elat);
      int c;
      do_div(a, b, c);
      check({tag, "_lat"}, 32'(c), 32'(elat));
      check({tag, "_q"}, 32'(bus.quotient), 32'(eq));
      check({tag, "_r"}, 32'(bus.remainder), 32'(er));
      check({tag, "_dbz"}, 32'(bus.div_by_zero), 32'(edbz));
      check({tag, "_busy"}, 32'(bus.busy), 32'(0));
      @(posedge clk);
      #1;
      check({tag, "_done_end"}, 32'(bus.done), 32'(0));
   endtask

   initial begin
      bus.start    = 1'b0;
      bus.dividend = '0;
      bus.divisor  = '0;
      #12;
      check("rst_busy", 32'(bus.busy), 32'(0));
      check("rst_done", 32'(bus.done), 32'(0));
      check("rst_q", 32'(bus.quotient), 32'(0));
      check("rst_r", 32'(bus.remainder), 32'(0));
      check("rst_dbz", 32'(bus.div_by_zero), 32'(0));
      #5 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // 15/2 cycle by cycle, with an ignored 9/3 start pulsed at E3.
      bus.start    = 1'b1;
      bus.dividend = 8'd15;
      bus.divisor  = 8'd2;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      check("e0_busy", 32'(bus.busy), 32'(1));
      for (int e = 1; e <= 8; e++) begin
         @(posedge clk);
         #1;
         if (e == 2) begin
            bus.start    = 1'b1;
            bus.dividend = 8'd9;
            bus.divisor  = 8'd3;
         end
         if (e == 3) bus.start = 1'b0;
         if (e < 8) begin
            check("calc_busy", 32'(bus.busy), 32'(1));
            check("calc_done", 32'(bus.done), 32'(0));
            check("calc_q_hold", 32'(bus.quotient), 32'(0));
         end
      end
      check("e8_done", 32'(bus.done), 32'(1));
      check("e8_busy", 32'(bus.busy), 32'(0));
      check("e8_q", 32'(bus.quotient), 32'(7));
      check("e8_r", 32'(bus.remainder), 32'(1));
      check("e8_dbz", 32'(bus.div_by_zero), 32'(0));
      @(posedge clk);
      #1;
      check("e9_done", 32'(bus.done), 32'(0));
      repeat (3) @(posedge clk);
      #1;
      check("hold_q", 32'(bus.quotient), 32'(7));
      check("hold_r", 32'(bus.remainder), 32'(1));
      check("hold_busy", 32'(bus.busy), 32'(0));

      div_check("d200_0", 8'd200, 8'd0, 8'hFF, 8'd200, 1'b1, 1);
      div_check("d100_7", 8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 8);

      // Reset after E4 of 255/16.
      bus.start    = 1'b1;
      bus.dividend = 8'd255;
      bus.divisor  = 8'd16;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("mid_rst_busy", 32'(bus.busy), 32'(0));
      check("mid_rst_done", 32'(bus.done), 32'(0));
      check("mid_rst_q", 32'(bus.quotient), 32'(0));
      check("mid_rst_r", 32'(bus.remainder), 32'(0));
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         check("mid_rst_nodone", 32'(bus.done), 32'(0));
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
`ifdef DIV_SIGNED_EN
      div_check("d255_16", 8'd255, 8'd16, 8'h00, 8'hFF, 1'b0, 8);
`else
      div_check("d255_16", 8'd255, 8'd16, 8'd15, 8'd15, 1'b0, 8);
`endif

      // Back-to-back: start is raised in the IDLE cycle right after DONE.
      do_div(8'd100, 8'd7, lat);
      check("b2b_a_lat", 32'(lat), 32'(8));
      @(posedge clk);
      #1;
      do_div(8'd50, 8'd5, lat);
      check("b2b_b_lat", 32'(lat), 32'(8));
      check("b2b_b_q", 32'(bus.quotient), 32'(10));
      check("b2b_b_r", 32'(bus.remainder), 32'(0));
      @(posedge clk);
      #1;

`ifdef DIV_SIGNED_EN
      div_check("s_m7_2", 8'hF9, 8'd2, 8'hFD, 8'hFF, 1'b0, 8);
      div_check("s_m128_m1", 8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 8);
      div_check("s_7_m2", 8'd7, 8'hFE, 8'hFD, 8'h01, 1'b0, 8);
      div_check("s_m128_0", 8'h80, 8'h00, 8'hFF, 8'h80, 1'b1, 1);
`else
      div_check("u255_255", 8'd255, 8'd255, 8'd1, 8'd0, 1'b0, 8);
      div_check("u7_9", 8'd7, 8'd9, 8'd0, 8'd7, 1'b0, 8);
      div_check("u255_1", 8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 8);
      div_check("u128_3", 8'd128, 8'd3, 8'd42, 8'd2, 1'b0, 8);
      div_check("u0_5", 8'd0, 8'd5, 8'd0, 8'd0, 1'b0, 8);
`endif

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
